// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA pattern generator.
//   pattern_mode_t : pattern select encoding (solid, bars, checker, box)
//   box_dir_t      : bouncing-box direction, bit1 = moving left, bit0 = moving up
//   rgb24_t        : 24-bit pixel payload
//   PALETTE        : fixed 8-entry colour palette
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } pattern_mode_t;

  typedef enum logic [1:0] {
    RIGHT_DOWN = 2'b00,
    RIGHT_UP   = 2'b01,
    LEFT_DOWN  = 2'b10,
    LEFT_UP    = 2'b11
  } box_dir_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam int unsigned PAL_N = 8;

  localparam rgb24_t PALETTE [PAL_N] = '{
    24'h3C3C3C, 24'h000080, 24'h008000, 24'h87CEEB,
    24'h800000, 24'hEE82EE, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/box_mover.sv
// Bouncing-box position and direction state, advanced once per frame.
//   clk, rst    : clock, async active-high reset
//   frame_evt   : one-clk frame event strobe
//   pause       : freezes motion when high
//   box_x/box_y : top-left corner of the box, active-relative pixels
module box_mover
  import vga_pattern_pkg::*;
#(
  parameter int unsigned H_SPAN   = 640,
  parameter int unsigned V_SPAN   = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_evt,
  input  logic       pause,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam int unsigned X_MAX = H_SPAN - BOX_SIZE;
  localparam int unsigned Y_MAX = V_SPAN - BOX_SIZE;

  box_dir_t   state_q, state_d;
  logic [9:0] x_d, y_d;
  logic       x_pos, y_pos;
  logic       nx_pos, ny_pos;

  // State and position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RIGHT_DOWN;
      box_x   <= '0;
      box_y   <= '0;
    end else begin
      state_q <= state_d;
      box_x   <= x_d;
      box_y   <= y_d;
    end
  end

  // Per-axis clamp-and-bounce; 11-bit compares keep pos+STEP from wrapping
  always_comb begin
    state_d = state_q;
    x_d     = box_x;
    y_d     = box_y;
    x_pos   = (state_q == RIGHT_DOWN) || (state_q == RIGHT_UP);
    y_pos   = (state_q == RIGHT_DOWN) || (state_q == LEFT_DOWN);
    nx_pos  = x_pos;
    ny_pos  = y_pos;
    if (frame_evt && !pause) begin
      if (x_pos) begin
        if (11'(box_x) + 11'(STEP) >= 11'(X_MAX)) begin
          x_d    = 10'(X_MAX);
          nx_pos = 1'b0;
        end else begin
          x_d = box_x + 10'(STEP);
        end
      end else begin
        if (box_x <= 10'(STEP)) begin
          x_d    = '0;
          nx_pos = 1'b1;
        end else begin
          x_d = box_x - 10'(STEP);
        end
      end
      if (y_pos) begin
        if (11'(box_y) + 11'(STEP) >= 11'(Y_MAX)) begin
          y_d    = 10'(Y_MAX);
          ny_pos = 1'b0;
        end else begin
          y_d = box_y + 10'(STEP);
        end
      end else begin
        if (box_y <= 10'(STEP)) begin
          y_d    = '0;
          ny_pos = 1'b1;
        end else begin
          y_d = box_y - 10'(STEP);
        end
      end
      state_d = nx_pos ? (ny_pos ? RIGHT_DOWN : RIGHT_UP)
                       : (ny_pos ? LEFT_DOWN  : LEFT_UP);
    end
  end

endmodule

// File: rtl/bit_gen_pattern.sv
// Pattern generator for the VGA pipeline: solid, colour bars, checkerboard
// or bouncing box, coloured from the fixed 8-entry palette.
//   clk, reset          : clock, async active-high reset
//   pix_en              : pixel-rate enable
//   bright              : active-video flag from the timing controller
//   hcount/vcount       : raster counters
//   mode, switches      : pattern select, palette index
//   pause               : freezes box motion
//   VGA_R/VGA_G/VGA_B   : registered colour channels (one pixel latency)
//   frame_tick          : one-clk pulse after the end-of-frame event
module bit_gen_pattern
  import vga_pattern_pkg::*;
#(
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_END    = 784,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_END    = 515,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               bright,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic [1:0]         mode,
  input  logic [2:0]         switches,
  input  logic               pause,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               frame_tick
);

  localparam int unsigned H_SPAN   = H_END - H_START;
  localparam int unsigned V_SPAN   = V_END - V_START;
  localparam int unsigned CELL_BIT = $clog2(BOX_SIZE);

  logic [9:0] ax, ay;
  logic [9:0] box_x, box_y;
  logic [2:0] bar_idx;
  logic       visible, cell_odd, in_box, frame_evt;
  rgb24_t     pix;

  box_mover #(
    .H_SPAN   (H_SPAN),
    .V_SPAN   (V_SPAN),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_box (
    .clk       (clk),
    .rst       (reset),
    .frame_evt (frame_evt),
    .pause     (pause),
    .box_x     (box_x),
    .box_y     (box_y)
  );

  // Visibility, active-relative coordinates and pattern selection
  always_comb begin
    ax        = hcount - 10'(H_START);
    ay        = vcount - 10'(V_START);
    visible   = bright && (hcount >= 10'(H_START)) && (hcount < 10'(H_END)) &&
                (vcount >= 10'(V_START)) && (vcount < 10'(V_END));
    bar_idx   = 3'({ax, 3'b000} / 13'(H_SPAN));
    cell_odd  = ax[CELL_BIT] ^ ay[CELL_BIT];
    in_box    = (ax >= box_x) && (11'(ax) < 11'(box_x) + 11'(BOX_SIZE)) &&
                (ay >= box_y) && (11'(ay) < 11'(box_y) + 11'(BOX_SIZE));
    frame_evt = pix_en && (hcount == 10'd0) && (vcount == 10'(V_END));
    pix       = '0;
    if (visible) begin
      case (pattern_mode_t'(mode))
        MODE_SOLID:   pix = PALETTE[switches];
        MODE_BARS:    pix = PALETTE[bar_idx];
        MODE_CHECKER: pix = cell_odd ? PALETTE[~switches] : PALETTE[switches];
        MODE_BOX:     if (in_box) pix = PALETTE[switches];
        default:      pix = '0;
      endcase
    end
  end

  // Output registers; channel value is the top COLOR_W bits of the entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_evt;
      if (pix_en) begin
        VGA_R <= pix.r[7 -: COLOR_W];
        VGA_G <= pix.g[7 -: COLOR_W];
        VGA_B <= pix.b[7 -: COLOR_W];
      end
    end
  end

endmodule

// File: tb/tb_bit_gen_pattern.sv
// Self-checking bench for bit_gen_pattern (COLOR_W=8 and COLOR_W=4 instances).
module tb_bit_gen_pattern;
  import vga_pattern_pkg::*;

  logic       clk = 1'b0;
  logic       reset, pix_en, bright, pause;
  logic [9:0] hcount, vcount;
  logic [1:0] mode;
  logic [2:0] switches;
  logic [7:0] r8, g8, b8;
  logic [3:0] r4, g4, b4;
  logic       ft8, ft4;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] expv;
  int  bx, by;
  bit  dxp, dyp;
  int  tick_cnt = 0;

  bit_gen_pattern #(.COLOR_W(8)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .bright(bright),
    .hcount(hcount), .vcount(vcount), .mode(mode), .switches(switches),
    .pause(pause), .VGA_R(r8), .VGA_G(g8), .VGA_B(b8), .frame_tick(ft8)
  );

  bit_gen_pattern #(.COLOR_W(4)) dut4 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .bright(bright),
    .hcount(hcount), .vcount(vcount), .mode(mode), .switches(switches),
    .pause(pause), .VGA_R(r4), .VGA_G(g4), .VGA_B(b4), .frame_tick(ft4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ft8 === 1'b1) tick_cnt++;

  function automatic logic [23:0] pal(int i);
    case (i)
      0: return 24'h3C3C3C;
      1: return 24'h000080;
      2: return 24'h008000;
      3: return 24'h87CEEB;
      4: return 24'h800000;
      5: return 24'hEE82EE;
      6: return 24'hFFFF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [23:0] model_rgb(int md, int sw, int h, int v, bit b);
    int ax, ay;
    ax = h - 144;
    ay = v - 35;
    if (!(b && h >= 144 && h < 784 && v >= 35 && v < 515)) return 24'h0;
    case (md)
      0: return pal(sw);
      1: return pal((ax * 8) / 640);
      2: return ((((ax / 32) ^ (ay / 32)) & 1) == 0) ? pal(sw) : pal(7 - sw);
      default:
        if (ax >= bx && ax < bx + 32 && ay >= by && ay < by + 32) return pal(sw);
        else return 24'h0;
    endcase
  endfunction

  task automatic model_frame();
    if (!pause) begin
      if (dxp) begin
        if (bx + 2 >= 608) begin bx = 608; dxp = 0; end else bx += 2;
      end else begin
        if (bx <= 2) begin bx = 0; dxp = 1; end else bx -= 2;
      end
      if (dyp) begin
        if (by + 2 >= 448) begin by = 448; dyp = 0; end else by += 2;
      end else begin
        if (by <= 2) begin by = 0; dyp = 1; end else by -= 2;
      end
    end
  endtask

  // Drive one pixel, record its expected colour, return #1 after the capturing edge
  task automatic drive_pixel(int h, int v, bit b);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = b;
    pix_en = 1'b1;
    exp_q.push_back(model_rgb(int'(mode), int'(switches), h, v, b));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
  endtask

  // One frame event (hcount=0, vcount=V_END), returning #1 after the edge
  task automatic do_frame();
    @(negedge clk);
    hcount = 10'd0;
    vcount = 10'd515;
    bright = 1'b0;
    pix_en = 1'b1;
    model_frame();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    pix_en = 1'b0;
    bx = 0; by = 0; dxp = 1; dyp = 1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({r8, g8, b8, ft8} !== 25'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%b want 000000/0", {r8, g8, b8}, ft8);
    end
    mode = 2'd0;
    switches = 3'd7;
    drive_pixel(200, 100, 1'b1);
    expv = exp_q.pop_front();
    n_cmp++;
    if ({r8, g8, b8} !== expv) begin
      n_err++;
      $display("FAIL pre_reset_white: got %h want %h", {r8, g8, b8}, expv);
    end
    #1;
    reset = 1'b1;
    bx = 0; by = 0; dxp = 1; dyp = 1;
    #1;
    n_cmp++;
    if ({r8, g8, b8} !== 24'h0) begin
      n_err++;
      $display("FAIL async_reset_clear: got %h want 000000", {r8, g8, b8});
    end
    idle(1);
    reset = 1'b0;
    n_cmp++;
    if (dut.u_box.box_x !== 10'd0 || dut.u_box.box_y !== 10'd0 || dut.u_box.state_q !== RIGHT_DOWN) begin
      n_err++;
      $display("FAIL reset_box: got (%0d,%0d,%0d) want (0,0,0)",
               dut.u_box.box_x, dut.u_box.box_y, dut.u_box.state_q);
    end
  endtask

  task automatic test_solid();
    int hs[5] = '{200, 100, 300, 783, 784};
    int vs[5] = '{100, 100, 200, 514, 514};
    bit bs[5] = '{1, 1, 0, 1, 1};
    mode = 2'd0;
    switches = 3'd3;
    for (int i = 0; i < 5; i++) begin
      drive_pixel(hs[i], vs[i], bs[i]);
      expv = exp_q.pop_front();
      n_cmp++;
      if ({r8, g8, b8} !== expv) begin
        n_err++;
        $display("FAIL solid[%0d] h=%0d v=%0d: got %h want %h", i, hs[i], vs[i], {r8, g8, b8}, expv);
      end
    end
    idle(1);
  endtask

  task automatic test_bars();
    int axs[5] = '{79, 80, 639, 0, 320};
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      drive_pixel(144 + axs[i], 100, 1'b1);
      expv = exp_q.pop_front();
      n_cmp++;
      if ({r8, g8, b8} !== expv) begin
        n_err++;
        $display("FAIL bars ax=%0d: got %h want %h", axs[i], {r8, g8, b8}, expv);
      end
    end
    idle(1);
  endtask

  task automatic test_checker();
    int axs[4] = '{0, 32, 32, 31};
    int ays[4] = '{0, 0, 32, 63};
    mode = 2'd2;
    switches = 3'd7;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(144 + axs[i], 35 + ays[i], 1'b1);
      expv = exp_q.pop_front();
      n_cmp++;
      if ({r8, g8, b8} !== expv) begin
        n_err++;
        $display("FAIL checker (%0d,%0d): got %h want %h", axs[i], ays[i], {r8, g8, b8}, expv);
      end
    end
    idle(1);
  endtask

  task automatic test_hold();
    mode = 2'd0;
    switches = 3'd5;
    drive_pixel(400, 300, 1'b1);
    expv = exp_q.pop_front();
    @(negedge clk);
    pix_en = 1'b0;
    switches = 3'd1;
    hcount = 10'd0;
    vcount = 10'd515;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({r8, g8, b8, ft8} !== {expv, 1'b0}) begin
      n_err++;
      $display("FAIL hold_no_pix_en: got %h/%b want %h/0", {r8, g8, b8}, ft8, expv);
    end
  endtask

  task automatic test_box_motion();
    int t0;
    apply_reset();
    mode = 2'd3;
    switches = 3'd6;
    pause = 1'b0;
    t0 = tick_cnt;
    for (int f = 0; f < 304; f++) begin
      do_frame();
      n_cmp++;
      if (ft8 !== 1'b1) begin
        n_err++;
        $display("FAIL frame_tick_high f=%0d: got %b want 1", f, ft8);
      end
      idle(1);
    end
    @(negedge clk);
    n_cmp++;
    if (tick_cnt - t0 !== 304) begin
      n_err++;
      $display("FAIL tick_count_304: got %0d want 304", tick_cnt - t0);
    end
    n_cmp++;
    if (dut.u_box.box_x !== 10'd608 || int'(dut.u_box.box_y) !== by) begin
      n_err++;
      $display("FAIL box_at_xmax: got (%0d,%0d) want (608,%0d)", dut.u_box.box_x, dut.u_box.box_y, by);
    end
    n_cmp++;
    if (dut.u_box.state_q !== box_dir_t'({~dxp, ~dyp})) begin
      n_err++;
      $display("FAIL box_dir_flip: got %0d want %0d", dut.u_box.state_q, {~dxp, ~dyp});
    end
    do_frame();
    idle(1);
    @(negedge clk);
    n_cmp++;
    if (dut.u_box.box_x !== 10'd606 || int'(dut.u_box.box_y) !== by) begin
      n_err++;
      $display("FAIL box_after_bounce: got (%0d,%0d) want (606,%0d)", dut.u_box.box_x, dut.u_box.box_y, by);
    end
    // Inside-corner, just-outside-right and just-below pixels
    drive_pixel(144 + bx, 35 + by, 1'b1);
    drive_pixel(144 + bx + 32, 35 + by, 1'b1);
    drive_pixel(144 + bx + 31, 35 + by + 32, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      expv = exp_q.pop_front();
      n_cmp++;
      if (i == 0 && expv !== 24'hFFFF00) begin
        n_err++;
        $display("FAIL box_model_inside: got %h want FFFF00", expv);
      end
    end
  endtask

  task automatic test_box_pixels();
    // Scoreboard entries are compared as each pixel's output lands
    mode = 2'd3;
    switches = 3'd4;
    for (int i = 0; i < 4; i++) begin
      int dx, dy;
      dx = (i == 1) ? 32 : ((i == 3) ? -1 : 0);
      dy = (i == 2) ? 31 : 0;
      drive_pixel(144 + bx + dx, 35 + by + dy, 1'b1);
      expv = exp_q.pop_front();
      n_cmp++;
      if ({r8, g8, b8} !== expv) begin
        n_err++;
        $display("FAIL box_pixel[%0d]: got %h want %h", i, {r8, g8, b8}, expv);
      end
    end
    idle(1);
  endtask

  task automatic test_pause();
    int t0, x0, y0;
    pause = 1'b1;
    t0 = tick_cnt;
    x0 = bx;
    y0 = by;
    for (int f = 0; f < 10; f++) begin
      do_frame();
      idle(1);
    end
    @(negedge clk);
    n_cmp++;
    if (tick_cnt - t0 !== 10) begin
      n_err++;
      $display("FAIL pause_ticks: got %0d want 10", tick_cnt - t0);
    end
    n_cmp++;
    if (int'(dut.u_box.box_x) !== x0 || int'(dut.u_box.box_y) !== y0) begin
      n_err++;
      $display("FAIL pause_frozen: got (%0d,%0d) want (%0d,%0d)", dut.u_box.box_x, dut.u_box.box_y, x0, y0);
    end
    pause = 1'b0;
  endtask

  task automatic test_color_w4();
    mode = 2'd0;
    switches = 3'd3;
    drive_pixel(200, 100, 1'b1);
    expv = exp_q.pop_front();
    idle(1);
    n_cmp++;
    if ({r4, g4, b4} !== {expv[23:20], expv[15:12], expv[7:4]} || {r4, g4, b4} !== 12'h8CE) begin
      n_err++;
      $display("FAIL color_w4: got %h want 8CE", {r4, g4, b4});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      mode     = 2'($urandom_range(0, 3));
      switches = 3'($urandom_range(0, 7));
      drive_pixel($urandom_range(100, 799), $urandom_range(20, 514), 1'($urandom_range(0, 1)));
      expv = exp_q.pop_front();
      n_cmp++;
      if ({r8, g8, b8} !== expv) begin
        n_err++;
        $display("FAIL b2b[%0d] mode=%0d h=%0d v=%0d: got %h want %h",
                 i, mode, hcount, vcount, {r8, g8, b8}, expv);
      end
    end
    idle(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    bright = 1'b0;
    pause = 1'b0;
    hcount = '0;
    vcount = '0;
    mode = '0;
    switches = '0;
    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_hold();
    test_box_motion();
    test_box_pixels();
    test_pause();
    test_color_w4();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
